// File: rtl/sm3_arbiter.sv
// sm3_arbiter: round-robin scheduler sharing one SM3 hash core between NREQ
// requesters. The winning message is registered and held stable while the
// core sits in reset. The arbiter then releases the core, waits for done, and
// returns the digest to its owner with a one-cycle response pulse.
// Optional feature macro: SM3_ARB_TIMEOUT_EN. When it is defined, a RUN-cycle
// watchdog aborts a stalled job with resp_err=1. When it is undefined, RUN
// waits for core_done indefinitely and resp_err is tied low.
module sm3_arbiter #(
  parameter int NREQ    = 2,
  parameter int MSG_W   = 544,
  parameter int TIMEOUT = 1023
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*MSG_W-1:0]   req_msg,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         resp_valid,
  output logic [255:0]            resp_hash,
  output logic                    resp_err,
  output logic                    busy,
  output logic                    core_rst_n,
  output logic [MSG_W-1:0]        core_msg,
  input  logic                    core_done,
  input  logic [255:0]            core_hash
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]       state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] owner;
  logic [PTR_W-1:0] grant;
  logic             any_req;

`ifdef SM3_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] run_cnt;
`endif

  // One-hot select line for a requester index.
  function automatic logic [NREQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    onehot = {{(NREQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Pointer to the requester after idx, wrapping NREQ-1 back to 0.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
    next_ptr = (idx == PTR_W'(NREQ - 1)) ? '0 : idx + PTR_W'(1);
  endfunction

  // Round-robin search from ptr upward; scanning offsets high-to-low lets the
  // smallest pending offset be the last (winning) assignment.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(ptr) + k) % NREQ]) begin
        grant   = PTR_W'((int'(ptr) + k) % NREQ);
        any_req = 1'b1;
      end
    end
  end

  // Job sequencer: capture, hold the core in reset one cycle, run, respond.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ptr        <= '0;
      owner      <= '0;
      core_rst_n <= 1'b0;
      req_ready  <= '0;
      resp_valid <= '0;
      busy       <= 1'b0;
      resp_hash  <= '0;
      core_msg   <= '0;
`ifdef SM3_ARB_TIMEOUT_EN
      resp_err   <= 1'b0;
      run_cnt    <= '0;
`endif
    end else begin
      req_ready  <= '0;
      resp_valid <= '0;
      case (state)
        S_IDLE: begin
          core_rst_n <= 1'b0;
          if (any_req) begin
            core_msg  <= req_msg[int'(grant) * MSG_W +: MSG_W];
            owner     <= grant;
            req_ready <= onehot(grant);
            busy      <= 1'b1;
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          core_rst_n <= 1'b1;
          state      <= S_RUN;
`ifdef SM3_ARB_TIMEOUT_EN
          run_cnt    <= '0;
`endif
        end
        S_RUN: begin
          if (core_done) begin
            resp_hash  <= core_hash;
            resp_valid <= onehot(owner);
            core_rst_n <= 1'b0;
            state      <= S_RESP;
`ifdef SM3_ARB_TIMEOUT_EN
            resp_err   <= 1'b0;
          end else if (run_cnt == CNT_W'(TIMEOUT)) begin
            resp_hash  <= '0;
            resp_err   <= 1'b1;
            resp_valid <= onehot(owner);
            core_rst_n <= 1'b0;
            state      <= S_RESP;
          end else begin
            run_cnt    <= run_cnt + CNT_W'(1);
`endif
          end
        end
        default: begin
          ptr        <= next_ptr(owner);
          busy       <= 1'b0;
          core_rst_n <= 1'b0;
          state      <= S_IDLE;
`ifdef SM3_ARB_TIMEOUT_EN
          resp_err   <= 1'b0;
`endif
        end
      endcase
    end
  end

`ifndef SM3_ARB_TIMEOUT_EN
  assign resp_err = 1'b0;
`endif

endmodule
